// File: rtl/red_pitaya_cordic_pkg.sv
// Shared CORDIC constants for the Red Pitaya rotation-mode and vectoring-mode
// blocks.
//
// Contents:
//   ATAN_TABLE      atan(2^-k)/(2*pi) in units of 2^-16 turn, k = 0..15
//   GAINCOMP        round(2^15 / 1.646760), the inverse of the CORDIC gain
//   GAINCOMP_SHIFT  fractional bits of GAINCOMP
//   cordic_atan()   table entry rounded to a phase accumulator of a given
//                   width. The accumulator holds the top zbits of the 16-bit
//                   turn word, so one LSB is 2^-zbits turn.
package red_pitaya_cordic_pkg;

    localparam int ATAN_FRAC_BITS = 16;

    localparam int ATAN_TABLE [0:15] = '{
        8192, 4836, 2555, 1297, 651, 326, 163, 81,
        41,   20,   10,   5,    3,   1,   1,   0
    };

    localparam int GAINCOMP       = 19898;
    localparam int GAINCOMP_SHIFT = 15;

    function automatic int cordic_atan(input int k, input int zbits);
        int s;
        s = ATAN_FRAC_BITS - zbits;
        if (s <= 0) begin
            return ATAN_TABLE[k] <<< (-s);
        end
        return (ATAN_TABLE[k] + (1 <<< (s - 1))) >>> s;
    endfunction

endpackage

// File: rtl/red_pitaya_cordic_rot_stage.sv
// One registered rotation-mode CORDIC micro-rotation.
//
// The residual angle z decides the direction. A non-negative z means the
// vector still has to turn counter-clockwise. All shifts are arithmetic. The
// register advances every cycle and has no enable.
//
// Parameters:
//   WW     x/y width
//   ZW     residual angle width, LSB = 2^-ZW turn
//   SHIFT  micro-rotation index k, which is the shift amount
//   ANGLE  atan(2^-k) in units of 2^-ZW turn
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   x_i, y_i, z_i   vector and residual angle from the previous stage
//   x_o, y_o, z_o   registered results
module red_pitaya_cordic_rot_stage #(
    parameter int WW    = 18,
    parameter int ZW    = 14,
    parameter int SHIFT = 0,
    parameter int ANGLE = 0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [WW-1:0] x_i,
    input  logic [WW-1:0] y_i,
    input  logic [ZW-1:0] z_i,
    output logic [WW-1:0] x_o,
    output logic [WW-1:0] y_o,
    output logic [ZW-1:0] z_o
);

    localparam logic [ZW-1:0] ANGLE_Z = ZW'(ANGLE);

    logic [WW-1:0] x_sh;
    logic [WW-1:0] y_sh;

    assign x_sh = $signed(x_i) >>> SHIFT;
    assign y_sh = $signed(y_i) >>> SHIFT;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_o <= '0;
            y_o <= '0;
            z_o <= '0;
        end else if (!z_i[ZW-1]) begin
            x_o <= x_i - y_sh;
            y_o <= y_i + x_sh;
            z_o <= z_i - ANGLE_Z;
        end else begin
            x_o <= x_i + y_sh;
            y_o <= y_i - x_sh;
            z_o <= z_i + ANGLE_Z;
        end
    end

endmodule

// File: rtl/red_pitaya_cordic_rotator.sv
// Pipelined rotation-mode CORDIC that turns (phase, amplitude) into an (i, q)
// pair. It is the inverse of the vectoring phase detector and uses the same
// phase encoding: an unsigned fraction of one turn, counter-clockwise positive.
//
// Ports:
//   clk_i    system clock
//   rstn_i   asynchronous reset, active low
//   valid_i  input sample strobe
//   phase_i  phase, turns * 2^PHASEWIDTH
//   amp_i    signed amplitude
//   i_o      amp*cos(phase) * 2^(OUTPUTWIDTH-INPUTWIDTH), symmetric saturation
//   q_o      amp*sin(phase) * 2^(OUTPUTWIDTH-INPUTWIDTH), symmetric saturation
//   valid_o  output strobe, aligned with i_o/q_o
//
// Handshake: valid-only streaming with no ready and no backpressure. Every
// sample presented with valid_i high is accepted on that clock edge. It
// appears on i_o/q_o with valid_o high exactly NSTAGES+2 cycles later. The
// datapath advances every cycle whatever valid_i is, and valid travels beside
// it as a tag. Reset empties the tag pipe, so no sample in flight survives it.
//
// Pipeline: stage 0 does the quadrant pre-rotation, NSTAGES micro-rotations
// follow, and the last register applies gain compensation, rounding and
// saturation.
module red_pitaya_cordic_rotator
    import red_pitaya_cordic_pkg::*;
#(
    parameter int INPUTWIDTH   = 12,
    parameter int OUTPUTWIDTH  = 14,
    parameter int WORKINGWIDTH = 18,
    parameter int PHASEWIDTH   = 12,
    parameter int NSTAGES      = 10
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   valid_i,
    input  logic [PHASEWIDTH-1:0]  phase_i,
    input  logic [INPUTWIDTH-1:0]  amp_i,
    output logic [OUTPUTWIDTH-1:0] i_o,
    output logic [OUTPUTWIDTH-1:0] q_o,
    output logic                   valid_o
);

    localparam int IW        = INPUTWIDTH;
    localparam int OW        = OUTPUTWIDTH;
    localparam int WW        = WORKINGWIDTH;
    localparam int PW        = PHASEWIDTH;
    localparam int ZW        = PW + 2;
    localparam int MSB_GUARD = 2;
    localparam int LSB_GUARD = WW - IW - MSB_GUARD;
    localparam int LAT       = NSTAGES + 2;
    // After gain compensation x carries amp * 2^LSB_GUARD. The output wants
    // amp * 2^(OW-IW), so one shift removes both the gain fraction and the
    // guard bits.
    localparam int OUT_SHIFT = GAINCOMP_SHIFT + LSB_GUARD - (OW - IW);
    localparam int PRODW     = WW + 16;

    localparam logic signed [PRODW-1:0] GAIN_W   = PRODW'(GAINCOMP);
    localparam logic signed [PRODW-1:0] ROUND_W  = PRODW'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [PRODW-1:0] SAT_MAX  = (PRODW'(1) <<< (OW - 1)) - PRODW'(1);
    localparam logic signed [PRODW-1:0] SAT_MIN  = -SAT_MAX;

    // ---------------------------------------------------------------- stage 0
    logic [1:0]    qd;
    logic [PW-1:0] res;
    logic [WW-1:0] a_ext;
    logic [WW-1:0] a_neg;
    logic [WW-1:0] x0_d;
    logic [WW-1:0] y0_d;
    logic [WW-1:0] x_s0;
    logic [WW-1:0] y_s0;
    logic [ZW-1:0] z_s0;

    // Round the phase to the nearest quadrant. Adding 1/8 turn only carries
    // into the top two bits through bit PW-3, so that bit alone is added.
    // A phase exactly on a quadrant edge therefore rounds up.
    assign qd    = phase_i[PW-1:PW-2] + {1'b0, phase_i[PW-3]};
    // The subtraction wraps mod one turn and gives a signed residual in
    // [-1/8, 1/8) turn.
    assign res   = phase_i - {qd, {(PW-2){1'b0}}};
    assign a_ext = {{MSB_GUARD{amp_i[IW-1]}}, amp_i, {LSB_GUARD{1'b0}}};
    assign a_neg = -a_ext;

    always_comb begin
        x0_d = '0;
        y0_d = '0;
        case (qd)
            2'd0:    x0_d = a_ext;
            2'd1:    y0_d = a_ext;
            2'd2:    x0_d = a_neg;
            default: y0_d = a_neg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_s0 <= '0;
            y_s0 <= '0;
            z_s0 <= '0;
        end else begin
            x_s0 <= x0_d;
            y_s0 <= y0_d;
            // The residual is held at 2^-(PW+2) turn so that it lines up
            // with the arctangent constants.
            z_s0 <= {res, 2'b00};
        end
    end

    // ------------------------------------------------------- micro-rotations
    logic [WW-1:0] x_pipe [0:NSTAGES];
    logic [WW-1:0] y_pipe [0:NSTAGES];
    logic [ZW-1:0] z_pipe [0:NSTAGES];
    logic [ZW-1:0] z_residual_unused;

    assign x_pipe[0] = x_s0;
    assign y_pipe[0] = y_s0;
    assign z_pipe[0] = z_s0;
    assign z_residual_unused = z_pipe[NSTAGES];

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        red_pitaya_cordic_rot_stage #(
            .WW    (WW),
            .ZW    (ZW),
            .SHIFT (k),
            .ANGLE (cordic_atan(k, ZW))
        ) u_stage (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .x_i    (x_pipe[k]),
            .y_i    (y_pipe[k]),
            .z_i    (z_pipe[k]),
            .x_o    (x_pipe[k+1]),
            .y_o    (y_pipe[k+1]),
            .z_o    (z_pipe[k+1])
        );
    end

    // ---------------------------------------------------------- output stage
    // Gain compensation, round-half-up, then symmetric saturation. The most
    // negative code is never produced.
    function automatic logic [OW-1:0] scale_sat(input logic [WW-1:0] v);
        logic signed [PRODW-1:0] prod;
        logic signed [PRODW-1:0] rounded;
        prod    = $signed({{(PRODW-WW){v[WW-1]}}, v}) * GAIN_W;
        rounded = (prod + ROUND_W) >>> OUT_SHIFT;
        if (rounded > SAT_MAX) begin
            return SAT_MAX[OW-1:0];
        end
        if (rounded < SAT_MIN) begin
            return SAT_MIN[OW-1:0];
        end
        return rounded[OW-1:0];
    endfunction

    logic [LAT-1:0] valid_sr;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            i_o      <= '0;
            q_o      <= '0;
            valid_sr <= '0;
        end else begin
            i_o      <= scale_sat(x_pipe[NSTAGES]);
            q_o      <= scale_sat(y_pipe[NSTAGES]);
            valid_sr <= {valid_sr[LAT-2:0], valid_i};
        end
    end

    assign valid_o = valid_sr[LAT-1];

endmodule

// File: tb/tb_red_pitaya_cordic_rotator.sv
// Directed bench for red_pitaya_cordic_rotator at default parameters.
// Ten micro-rotations leave a residual angle of a few 2^-16 turn. At full
// scale that is up to about 12 LSB across the ideal vector, so components
// that should be near zero, and diagonal points, get TOL_ANG. Magnitudes
// along an axis get TOL_AXIS.
module tb_red_pitaya_cordic_rotator;

    localparam int    LAT      = 12;
    localparam int    FS       = 8188;
    localparam int    TOL_AXIS = 4;
    localparam int    TOL_ANG  = 16;
    localparam int    DIAG     = 5790;
    localparam int    NRAMP    = 4096 + 32;
    localparam int    MAX_JUMP = 96;
    localparam real   TWO_PI   = 6.283185307179586;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic [11:0] phase_i;
    logic [11:0] amp_i;
    logic [13:0] i_o;
    logic [13:0] q_o;
    logic        valid_o;

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------- clock and reset
    always #5 clk = ~clk;

    red_pitaya_cordic_rotator dut (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .phase_i (phase_i),
        .amp_i   (amp_i),
        .i_o     (i_o),
        .q_o     (q_o),
        .valid_o (valid_o)
    );

    // --------------------------------------------------------- checkers
    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input longint exp,
                              input longint tol);
        logic ok;
        ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // -------------------------------------------------------- driver tasks
    // Sends one sample, then watches valid_o for LAT+8 cycles. It returns
    // the first output sample, its latency in cycles and the number of
    // valid_o pulses seen.
    task automatic run_vec(input int ph, input int am, output int io, output int qo,
                           output int lat, output int pulses);
        @(negedge clk);
        phase_i = 12'(ph);
        amp_i   = 12'(am);
        valid_i = 1'b1;
        lat     = -1;
        pulses  = 0;
        io      = 0;
        qo      = 0;
        for (int n = 1; n <= LAT + 8; n++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (valid_o) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    io  = int'($signed(i_o));
                    qo  = int'($signed(q_o));
                end
            end
        end
    endtask

    // ------------------------------------------------------------ stimulus
    int     io, qo, lat, pulses;
    int     cur_i, cur_q, prev_i, prev_q;
    longint pw;
    int     ph, am, rec, diff;
    real    ang;

    initial begin
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        phase_i = '0;
        amp_i   = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_i", int'($signed(i_o)), 0);
        check_eq("reset_q", int'($signed(q_o)), 0);
        check_eq("reset_valid", valid_o, 0);
        rstn_i = 1'b1;
        repeat (2) @(negedge clk);

        // Full-scale amplitude at each axis.
        run_vec(12'h000, 2047, io, qo, lat, pulses);
        check_eq("p000_latency", lat, LAT);
        check_eq("p000_pulses", pulses, 1);
        check_near("p000_i", io, FS, TOL_AXIS);
        check_near("p000_q", qo, 0, TOL_ANG);

        run_vec(12'h400, 2047, io, qo, lat, pulses);
        check_eq("p400_latency", lat, LAT);
        check_near("p400_i", io, 0, TOL_ANG);
        check_near("p400_q", qo, FS, TOL_AXIS);

        run_vec(12'h800, 2047, io, qo, lat, pulses);
        check_near("p800_i", io, -FS, TOL_AXIS);
        check_near("p800_q", qo, 0, TOL_ANG);

        run_vec(12'hC00, 2047, io, qo, lat, pulses);
        check_near("pC00_i", io, 0, TOL_ANG);
        check_near("pC00_q", qo, -FS, TOL_AXIS);

        // Quadrant edges and diagonals.
        run_vec(12'h200, 2047, io, qo, lat, pulses);
        check_near("p200_i", io, DIAG, TOL_ANG);
        check_near("p200_q", qo, DIAG, TOL_ANG);
        run_vec(12'h1FF, 2047, io, qo, lat, pulses);
        check_near("p1FF_i", io, DIAG, TOL_ANG);
        check_near("p1FF_q", qo, DIAG, TOL_ANG);
        run_vec(12'h600, 2047, io, qo, lat, pulses);
        check_near("p600_i", io, -DIAG, TOL_ANG);
        check_near("p600_q", qo, DIAG, TOL_ANG);

        // Most-negative amplitude: saturates symmetrically and never wraps.
        run_vec(12'h000, -2048, io, qo, lat, pulses);
        check_near("neg_p000_i", io, -8191, TOL_AXIS);
        check_eq("neg_p000_no_min_code", io == -8192, 0);
        check_near("neg_p000_q", qo, 0, TOL_ANG);
        run_vec(12'h800, -2048, io, qo, lat, pulses);
        check_near("neg_p800_i", io, 8191, TOL_AXIS);
        check_near("neg_p800_q", qo, 0, TOL_ANG);

        // Zero amplitude gives an exact zero at any phase.
        run_vec(12'h000, 0, io, qo, lat, pulses);
        check_eq("zero_p000_i", io, 0);
        check_eq("zero_p000_q", qo, 0);
        run_vec(12'h5A3, 0, io, qo, lat, pulses);
        check_eq("zero_p5A3_i", io, 0);
        check_eq("zero_p5A3_q", qo, 0);
        check_eq("zero_p5A3_latency", lat, LAT);

        // Continuous phase ramp through the 0xFFF -> 0x000 wrap.
        prev_i = 0;
        prev_q = 0;
        for (int n = 0; n <= NRAMP + LAT; n++) begin
            @(negedge clk);
            if (n < LAT) begin
                check_eq("ramp_pre_valid", valid_o, 0);
            end else if (n < NRAMP + LAT) begin
                cur_i = int'($signed(i_o));
                cur_q = int'($signed(q_o));
                check_eq("ramp_valid", valid_o, 1);
                pw = longint'(cur_i) * cur_i + longint'(cur_q) * cur_q;
                check_near("ramp_power", pw, longint'(FS) * FS, longint'(FS) * FS / 1000);
                if (n > LAT) begin
                    check_near("ramp_step_i", cur_i, prev_i, MAX_JUMP);
                    check_near("ramp_step_q", cur_q, prev_q, MAX_JUMP);
                end
                prev_i = cur_i;
                prev_q = cur_q;
            end else begin
                check_eq("ramp_end_valid", valid_o, 0);
            end
            phase_i = 12'(n);
            amp_i   = 12'd2047;
            valid_i = (n < NRAMP);
        end

        // Phase recovered from (i, q) matches the input phase.
        for (int t = 0; t < 16; t++) begin
            ph = $urandom_range(0, 4095);
            am = $urandom_range(1024, 2047);
            run_vec(ph, am, io, qo, lat, pulses);
            ang = $atan2(real'(qo), real'(io)) / TWO_PI * 4096.0;
            rec = int'(ang);
            diff = ((rec - ph) % 4096 + 4096 + 2048) % 4096 - 2048;
            check_near("phase_recovery", diff, 0, 3);
        end

        // Reset while five samples are in flight.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            valid_i = 1'b1;
            phase_i = 12'(k * 256);
            amp_i   = 12'd2047;
        end
        @(negedge clk);
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rstn_i = 1'b0;
        #1;
        check_eq("midreset_i", int'($signed(i_o)), 0);
        check_eq("midreset_q", int'($signed(q_o)), 0);
        check_eq("midreset_valid", valid_o, 0);
        @(negedge clk);
        check_eq("midreset_hold_valid", valid_o, 0);
        rstn_i = 1'b1;
        pulses = 0;
        for (int n = 0; n < LAT + 12; n++) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        check_eq("post_reset_no_stale_valid", pulses, 0);
        run_vec(12'h000, 2047, io, qo, lat, pulses);
        check_eq("post_reset_latency", lat, LAT);
        check_eq("post_reset_pulses", pulses, 1);
        check_near("post_reset_i", io, FS, TOL_AXIS);

        // ---------------------------------------------------------- report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
